// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised MIPS register file with post-reset clear sweep
// Optional write-first forwarding when REGMEM_BYPASS_EN is defined.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       RegWrite,
    input  logic [ADDR_W-1:0]          WriteReg,
    input  logic [DATA_W-1:0]          WriteData,
    input  logic [NUM_RD*ADDR_W-1:0]   ReadReg,
    output logic [NUM_RD*DATA_W-1:0]   ReadData,
    output logic                       Ready,
    output logic                       WrDrop
);

    typedef enum logic {INIT, RUN} state_e;

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  clr_idx_q, clr_idx_d;
    logic               wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic wr_in_range;
    logic wr_zero;
    logic wr_commit;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        wr_in_range = in_range(WriteReg);
        wr_zero     = is_zero_reg(WriteReg);
        wr_commit   = (state_q == RUN) && RegWrite && wr_in_range && !wr_zero;
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wr_drop_d = 1'b0;
        case (state_q)
            INIT: begin
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                wr_drop_d = RegWrite;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = RUN;
                    clr_idx_d = '0;
                end
            end
            RUN: begin
                // Zero-register writes are a legal discard and stay silent.
                wr_drop_d = RegWrite && !wr_in_range;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= INIT;
            clr_idx_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Array has no reset; the INIT sweep is what makes its contents defined.
    always_ff @(posedge Clk) begin
        if (state_q == INIT) begin
            mem[clr_idx_q] <= '0;
        end else if (wr_commit) begin
            mem[WriteReg] <= WriteData;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        always_comb begin
            ra = ReadReg[i*ADDR_W +: ADDR_W];
            rd = '0;
            if ((state_q == RUN) && in_range(ra) && !is_zero_reg(ra)) begin
`ifdef REGMEM_BYPASS_EN
                if (wr_commit && (WriteReg == ra)) begin
                    rd = WriteData;
                end else begin
                    rd = mem[ra];
                end
`else
                rd = mem[ra];
`endif
            end
        end

        assign ReadData[i*DATA_W +: DATA_W] = rd;
    end

    assign Ready  = (state_q == RUN);
    assign WrDrop = wr_drop_q;

endmodule
